// File: rtl/io_map_pkg.sv
// Shared IO map definitions: word-select bits, status field layout,
// and the UART transmit FSM state encoding.
package io_map_pkg;

  localparam int IO_LEDS_BIT        = 0;
  localparam int IO_UART_DATA_BIT   = 1;
  localparam int IO_UART_STATUS_BIT = 2;

  localparam int ST_CNT_LSB  = 0;
  localparam int ST_CNT_W    = 5;
  localparam int ST_OVF_BIT  = 7;
  localparam int ST_FULL_BIT = 8;
  localparam int ST_BUSY_BIT = 9;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // FIFO occupancy clipped to the width of the status count field.
  function automatic logic [ST_CNT_W-1:0] sat_count(input int unsigned c);
    return (c > 31) ? 5'd31 : 5'(c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a count register; full/empty derive from the count.
// A push is judged against the full flag at the start of the cycle, so a
// push into a full FIFO is dropped even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
)(
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped IO block: LED register plus FIFO-buffered UART transmitter.
// Word select is one-hot on io_addr[15:2]; io_rdata is combinational.
// Define IO_UART_PARITY_EN to insert an even-parity bit before the stop bit.
module io_uart_tx
  import io_map_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_wr,
  output logic [31:0] io_rdata,
  output logic        uart_txd,
  output logic [5:0]  leds
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int BCW = $clog2(DIV);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [13:0]    w_word;
  logic           w_sel_leds, w_sel_data, w_sel_status;
  logic           w_wr_leds, w_wr_data, w_wr_status;
  logic           w_fifo_full, w_fifo_empty, w_pop;
  logic [CW-1:0]  w_fifo_count;
  logic [7:0]     w_fifo_rdata;
  logic [5:0]     r_leds;
  logic           r_ovf;
  tx_state_e      r_state, w_state_nxt;
  logic [BCW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [2:0]     r_bit_idx, w_bit_idx_nxt;
  logic [7:0]     r_shift;
  logic           r_txd, w_txd_cur, w_bit_end, w_busy;
  logic [31:0]    w_rd_status;
  logic           w_unused;

  assign w_word       = io_addr[15:2];
  assign w_sel_leds   = w_word[IO_LEDS_BIT];
  assign w_sel_data   = w_word[IO_UART_DATA_BIT];
  assign w_sel_status = w_word[IO_UART_STATUS_BIT];
  assign w_wr_leds    = io_wr & w_sel_leds;
  assign w_wr_data    = io_wr & w_sel_data;
  assign w_wr_status  = io_wr & w_sel_status;
  assign w_unused     = ^{io_addr[31:16], io_addr[1:0], w_word[13:3], io_wdata[31:8]};

  sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_wr_data),
    .i_wdata (io_wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // LED register, loaded by stores to the LEDS word.
  always_ff @(posedge clk) begin
    if (!resetn)        r_leds <= '0;
    else if (w_wr_leds) r_leds <= io_wdata[5:0];
  end

  // Sticky overflow: a dropped push wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn)                          r_ovf <= 1'b0;
    else if (w_wr_data && w_fifo_full)    r_ovf <= 1'b1;
    else if (w_wr_status && io_wdata[0])  r_ovf <= 1'b0;
  end

  assign w_bit_end = (r_bit_cnt == BCW'(DIV - 1));

  // Transmit FSM state and bit timing registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= TX_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
    end
  end

  // Next-state logic; also decides the pop and the line level for this state.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = w_bit_end ? '0 : r_bit_cnt + BCW'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_pop         = 1'b0;
    w_txd_cur     = 1'b1;
    case (r_state)
      TX_IDLE: begin
        w_bit_cnt_nxt = '0;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = TX_START;
        end
      end
      TX_START: begin
        w_txd_cur = 1'b0;
        if (w_bit_end) begin
          w_state_nxt   = TX_DATA;
          w_bit_idx_nxt = '0;
        end
      end
      TX_DATA: begin
        w_txd_cur = r_shift[r_bit_idx];
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
`ifdef IO_UART_PARITY_EN
            w_state_nxt = TX_PARITY;
`else
            w_state_nxt = TX_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef IO_UART_PARITY_EN
      TX_PARITY: begin
        w_txd_cur = ^r_shift;
        if (w_bit_end) w_state_nxt = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (w_bit_end) w_state_nxt = TX_IDLE;
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  // Frame byte is captured at the pop; held unshifted and indexed per bit.
  always_ff @(posedge clk) begin
    if (w_pop) r_shift <= w_fifo_rdata;
  end

  // Registered line output, one cycle behind the state that drives it.
  always_ff @(posedge clk) begin
    if (!resetn) r_txd <= 1'b1;
    else         r_txd <= w_txd_cur;
  end

  assign uart_txd = r_txd;
  assign leds     = r_leds;
  assign w_busy   = ~w_fifo_empty | (r_state != TX_IDLE);

  // Status word assembly for core loads.
  always_comb begin
    w_rd_status = '0;
    w_rd_status[ST_CNT_LSB +: ST_CNT_W] = sat_count(32'(w_fifo_count));
    w_rd_status[ST_OVF_BIT]  = r_ovf;
    w_rd_status[ST_FULL_BIT] = w_fifo_full;
    w_rd_status[ST_BUSY_BIT] = w_busy;
  end

  assign io_rdata = (w_sel_leds   ? {26'b0, r_leds} : 32'b0) |
                    (w_sel_status ? w_rd_status     : 32'b0);

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped IO peripheral directly downstream of the core's IO port (io_addr/io_wdata/io_wr out, io_rdata in); replaces the bench-only character-print path.
- Drives the LED register and a buffered 8N1 UART transmitter behind a FIFO.
- Returns status to core loads through combinational io_rdata; the core samples it in its memory stage.

Parameters:
- CLK_FREQ_HZ, 27000000, system clock frequency.
- BAUD, 115200, line rate; bit period DIV = CLK_FREQ_HZ/BAUD (integer, truncated, must be >=2).
- FIFO_DEPTH, 16, TX FIFO entries, power of two, >=2.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- io_addr  in  32  IO byte address from core; word select = io_addr[15:2]
- io_wdata  in  32  IO write data
- io_wr  in  1  IO write strobe, one cycle per store
- io_rdata  out  32  IO read data, combinational from io_addr and registered state
- uart_txd  out  1  serial output, idle high
- leds  out  6  LED register

Behaviour:
- Word map (one-hot on io_addr[15:2]): bit0 LEDS, bit1 UART_DATA, bit2 UART_STATUS. Several bits set: every selected register acts.
- LEDS write: leds <= io_wdata[5:0]. Reset 0.
- UART_DATA write: push io_wdata[7:0] if FIFO not full at the start of the cycle; else drop it and set sticky ovf.
- UART_STATUS write with io_wdata[0]=1: clear ovf. A clear and an overflow in the same cycle leave ovf=1.
- Read UART_STATUS: [4:0]=count (saturates at 31), [7]=ovf, [8]=full, [9]=busy (count!=0 or FSM not IDLE), others 0.
- Read LEDS: {26'b0, leds}. Any other address reads 0. Reads have no side effects.
- FSM IDLE->START->DATA->STOP->IDLE. Bit counter 0..DIV-1; each state lasts DIV cycles.
- IDLE: txd=1. If FIFO not empty, pop into shift register and enter START next cycle.
- START: txd=0. DATA: 8 bits LSB first, bit index 0..7. STOP: txd=1 for one bit period.
- At end of STOP, go to IDLE. A pop can occur in the following cycle, giving a 1-cycle idle gap between frames.
- Latency: write to UART_DATA on an empty, idle FIFO -> txd falls 2 cycles after the write edge.
- Simultaneous push and pop: count unchanged. When full, the push is judged before the pop, so it is dropped.
- Pointers wrap modulo FIFO_DEPTH; full and empty come from a count register.
- Reset: synchronous, overrides everything, including mid-frame.
- Reset values: txd=1, leds=0, FIFO empty, ovf=0, FSM IDLE, counters 0. A frame in progress is abandoned with no stop bit.
- Outputs are registered (txd, leds); io_rdata is combinational.

Optional Feature:
- IO_UART_PARITY_EN defined: a PARITY state is inserted between DATA and STOP for one bit period, sending even parity (XOR of the 8 data bits). Frame = 11 bit periods.
- Undefined: pure 8N1, 10 bit periods, no PARITY state.

Decomposition:
- Shared package io_map_pkg holds:
  - word-select bit indices (IO_LEDS_BIT=0, IO_UART_DATA_BIT=1, IO_UART_STATUS_BIT=2);
  - status field positions;
  - the FSM state encoding.
- Sub-module sync_fifo (DATA_W, DEPTH; push/pop/full/empty/count) is natural and reusable for a later RX path.

Test Plan:
- CLK_FREQ_HZ=100, BAUD=10 (DIV=10). Write 0x55 to UART_DATA -> txd low at +2 cycles for 10 cycles, then 1,0,1,0,1,0,1,0 each 10 cycles, then high for 10 cycles. Status busy=1 during the frame, 0 afterwards.
- Write 0x41, 0x42, 0x43 back-to-back -> count reads 2 after the first pop. Three frames in order with 1-cycle gaps. Final status = 0.
- With DIV=10, write 20 bytes without waiting -> bytes 1..17 transmitted (1 popped + 16 buffered). full=1 while full, ovf=1, further writes dropped. Write 1 to UART_STATUS -> ovf=0.
- Push while full in the same cycle as a pop -> push dropped, count stays FIFO_DEPTH-1 after the pop, ovf=1.
- Write 0x3F to LEDS -> leds=0x3F next cycle, read back 0x3F. Read an unmapped word -> 0.
- Assert resetn=0 mid-DATA of frame 0xA5 with 3 bytes queued -> next cycle txd=1, status=0, leds=0, no further frames. With IO_UART_PARITY_EN, frame 0x07 carries parity bit 1 before stop.
